fpu_round_pack: RTL

- Final stage of the single-precision FPU datapath. It sits directly downstream of the add/sub/mul/div arithmetic core.
- Consumes an unrounded result: sign, wide biased exponent, extended mantissa with guard/round/sticky bits.
- Normalizes, rounds per mode_in, packs IEEE 754 binary32, and raises exception flags.
- Two-stage pipeline with valid/ready handshake on both sides; throughput of 1 result per cycle.

---
 rtl/fpu_pkg.sv | 30 +++
 rtl/fpu_lzc.sv | 17 +
 rtl/fpu_round_pack.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared constants and stage-1 register layout for the binary32 round/pack stage.
package fpu_pkg;

  localparam int EXP_W_DEF  = 10;
  localparam int MANT_W_DEF = 28;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [30:0] MAXF = 31'h7F7FFFFF;

  // mant: [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky
  typedef struct packed {
    logic                 sign;
    logic                 nan;
    logic                 inf;
    logic                 zero;
    logic                 tiny;
    logic [1:0]           mode;
    logic [EXP_W_DEF-1:0] exp;
    logic [26:0]          mant;
  } s1_t;

endpackage

// File: rtl/fpu_lzc.sv
// 27-bit leading-zero counter; cnt reads 27 and all_zero is set when d is zero.
module fpu_lzc (
  input  logic [26:0] d,
  output logic [4:0]  cnt,
  output logic        all_zero
);

  always_comb begin
    cnt = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (d[i]) cnt = 5'(26 - i);
    end
  end

  assign all_zero = (d == '0);

endmodule

// File: rtl/fpu_round_pack.sv
// Two-stage normalize / round / pack to IEEE binary32 with exception flags.
// Gradual underflow is built only when FPU_DENORM_EN is defined; otherwise tiny results flush to zero.
module fpu_round_pack
  import fpu_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_nan,
  input  logic              in_inf,
  input  logic [1:0]        mode_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out,
  output logic              overflow,
  output logic              underflow,
  output logic              in_exact,
  output logic              zero,
  output logic              op_nan
);

  logic s1_valid;
  logic s1_advance;
  s1_t  s1_d;
  s1_t  s1_q;

  assign s1_advance = ~out_valid | out_ready;
  assign in_ready   = ~s1_valid | s1_advance;

  // ---------------- stage 1: normalize ----------------
  logic [4:0]              lz;
  logic                    lz_zero;
  logic                    mant_zero;
  logic signed [EXP_W-1:0] exp_n;
  logic [26:0]             mant_n;
  logic                    tiny_n;

  fpu_lzc u_lzc (
    .d        (in_mant[26:0]),
    .cnt      (lz),
    .all_zero (lz_zero)
  );

  assign mant_zero = lz_zero & ~in_mant[27];

  always_comb begin
    if (in_mant[27]) begin
      mant_n = {in_mant[27:2], in_mant[1] | in_mant[0]};
      exp_n  = in_exp + EXP_W'(1);
    end else begin
      mant_n = in_mant[26:0] << lz;
      exp_n  = in_exp - EXP_W'(lz);
    end
  end

  assign tiny_n = ~mant_zero & (exp_n[EXP_W-1] | (exp_n == '0));

`ifdef FPU_DENORM_EN
  logic [EXP_W:0] dn_amt;
  logic [4:0]     dn_sh;
  logic [26:0]    dn_mask;
  logic [26:0]    dn_mant;

  // Only meaningful for tiny inputs, where 1-exp is positive.
  always_comb begin
    dn_amt     = (EXP_W+1)'(1) - {exp_n[EXP_W-1], exp_n};
    dn_sh      = (dn_amt > (EXP_W+1)'(27)) ? 5'd27 : dn_amt[4:0];
    dn_mask    = ~(27'h7FFFFFF << dn_sh);
    dn_mant    = mant_n >> dn_sh;
    dn_mant[0] = dn_mant[0] | (|(mant_n & dn_mask));
  end
`endif

  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_sign;
    s1_d.nan  = in_nan;
    s1_d.inf  = in_inf & ~in_nan;
    s1_d.zero = mant_zero & ~in_nan & ~in_inf;
    s1_d.tiny = tiny_n & ~in_nan & ~in_inf;
    s1_d.mode = mode_in;
    s1_d.exp  = exp_n;
    s1_d.mant = mant_n;
`ifdef FPU_DENORM_EN
    if (s1_d.tiny) begin
      s1_d.exp  = '0;
      s1_d.mant = dn_mant;
    end
`endif
  end

  // ---------------- stage 2: round / pack ----------------
  logic                  lsb, g, r, s;
  logic                  inexact;
  logic                  inc;
  logic                  inc_rne;
  logic                  rne_carry;
  logic                  away;
  logic [24:0]           sum;
  logic signed [EXP_W:0] exp_x;
  logic signed [EXP_W:0] exp_r;
  logic signed [EXP_W:0] exp_rne;
  logic                  ovf;
  logic [31:0]           res;
  logic                  res_ovf;
  logic                  res_uf;
  logic                  res_inx;
  logic                  res_nan;
  logic                  res_zero;

  always_comb begin
    lsb     = s1_q.mant[3];
    g       = s1_q.mant[2];
    r       = s1_q.mant[1];
    s       = s1_q.mant[0];
    inexact = g | r | s;
    inc_rne = g & (r | s | lsb);

    case (s1_q.mode)
      RM_RNE:  begin inc = inc_rne;               away = 1'b1;        end
      RM_RTZ:  begin inc = 1'b0;                  away = 1'b0;        end
      RM_RUP:  begin inc = ~s1_q.sign & inexact;  away = ~s1_q.sign;  end
      default: begin inc = s1_q.sign & inexact;   away = s1_q.sign;   end
    endcase

    sum       = {1'b0, s1_q.mant[26:3]} + {24'd0, inc};
    rne_carry = inc_rne & (&s1_q.mant[26:3]);

    // A subnormal carries into the hidden bit (exp field 0 -> 1); a normal carries out of it.
    exp_x   = {s1_q.exp[EXP_W_DEF-1], s1_q.exp};
    exp_r   = exp_x + {{EXP_W{1'b0}}, (s1_q.tiny ? sum[23] : sum[24])};
    exp_rne = exp_x + {{EXP_W{1'b0}}, rne_carry};

    // Overflow is judged on both the mode-rounded and the nearest-rounded magnitude, so a
    // value that would round past MAXF raises overflow even when the mode truncates it.
    ovf = ~s1_q.tiny &
          ((exp_r   >= $signed((EXP_W+1)'(EXP_MAX))) |
           (exp_rne >= $signed((EXP_W+1)'(EXP_MAX))));

    res     = {s1_q.sign, exp_r[7:0], sum[22:0]};
    res_ovf = 1'b0;
    res_uf  = s1_q.tiny & inexact;
    res_inx = inexact;
    res_nan = 1'b0;

    if (s1_q.nan) begin
      res     = QNAN;
      res_uf  = 1'b0;
      res_inx = 1'b0;
      res_nan = 1'b1;
    end else if (s1_q.inf) begin
      res     = {s1_q.sign, 8'hFF, 23'h0};
      res_uf  = 1'b0;
      res_inx = 1'b0;
    end else if (s1_q.zero) begin
      res     = {s1_q.sign, 31'h0};
      res_uf  = 1'b0;
      res_inx = 1'b0;
`ifndef FPU_DENORM_EN
    end else if (s1_q.tiny) begin
      res     = {s1_q.sign, 31'h0};
      res_uf  = 1'b1;
      res_inx = 1'b1;
`endif
    end else if (ovf) begin
      res_ovf = 1'b1;
      res_inx = 1'b1;
      res     = away ? {s1_q.sign, 8'hFF, 23'h0} : {s1_q.sign, MAXF};
    end
  end

  assign res_zero = (res[30:0] == '0);

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      in_exact  <= 1'b0;
      zero      <= 1'b0;
      op_nan    <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s1_advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out       <= res;
          overflow  <= res_ovf;
          underflow <= res_uf;
          in_exact  <= res_inx;
          zero      <= res_zero;
          op_nan    <= res_nan;
        end
      end
    end
  end

endmodule
